// File: rtl/led_chaser_multi.sv
// LED pattern generator with four animation modes (shift-right, shift-left,
// bounce, fill-bar), stepped by an enable-gated prescaler.
module led_chaser_multi #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             seq_done
);

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] PAT_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PAT_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PAT_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [WIDTH-1:0] led_q, led_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             step_q, step_d;
  logic             seq_done_q, seq_done_d;

  logic             tick;
  logic [WIDTH-1:0] next_pat;
  dir_t             next_dir;

  function automatic logic [WIDTH-1:0] start_pat(input logic [1:0] m);
    case (m)
      2'd1:    return PAT_LSB;
      2'd3:    return '0;
      default: return PAT_MSB;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - PAT_LSB)) == '0);
  endfunction

  // A fill-bar value is ones from the MSB down, so its inverse is of the form 0..01..1.
  function automatic logic is_thermo(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] inv;
    inv = ~v;
    return (inv & (inv + PAT_LSB)) == '0;
  endfunction

  always_comb begin
    tick     = en && (cnt_q == CNT_LAST);
    next_pat = led_q;
    next_dir = dir_q;
    case (mode_q)
      2'd0: begin
        if (is_one_hot(led_q)) next_pat = {led_q[0], led_q[WIDTH-1:1]};
        else                   next_pat = start_pat(2'd0);
      end
      2'd1: begin
        if (is_one_hot(led_q)) next_pat = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        else                   next_pat = start_pat(2'd1);
      end
      2'd2: begin
        if (!is_one_hot(led_q)) begin
          next_pat = start_pat(2'd2);
          next_dir = DIR_RIGHT;
        end else if (dir_q == DIR_RIGHT) begin
          next_pat = led_q >> 1;
          if (led_q == (PAT_LSB << 1)) next_dir = DIR_LEFT;
        end else begin
          next_pat = led_q << 1;
          if (led_q == (PAT_MSB >> 1)) next_dir = DIR_RIGHT;
        end
      end
      default: begin
        if (!is_thermo(led_q))      next_pat = start_pat(2'd3);
        else if (led_q == PAT_ONES) next_pat = '0;
        else                        next_pat = (led_q >> 1) | PAT_MSB;
      end
    endcase
  end

  // Reset and a mode change both restart the animation; a mode change wins over a tick.
  always_comb begin
    led_d      = led_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    seq_done_d = 1'b0;
    if (reset || (mode != mode_q)) begin
      led_d  = start_pat(mode);
      mode_d = mode;
      cnt_d  = '0;
      dir_d  = DIR_RIGHT;
    end else if (tick) begin
      led_d      = next_pat;
      dir_d      = next_dir;
      cnt_d      = '0;
      step_d     = 1'b1;
      seq_done_d = (next_pat == start_pat(mode_q));
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    led_q      <= led_d;
    mode_q     <= mode_d;
    cnt_q      <= cnt_d;
    dir_q      <= dir_d;
    step_q     <= step_d;
    seq_done_q <= seq_done_d;
  end

  assign led      = led_q;
  assign step     = step_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_led_chaser_multi.sv
// Self-checking bench for led_chaser_multi: table vectors, corner sequences and
// random stimulus against a phase-index reference model, on DIV=1 and DIV=3 instances.
module tb_led_chaser_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] led1, led3;
  logic       step1, step3, done1, done3;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: 0 -> DIV=1, 1 -> DIV=3.
  int         mDiv[2] = '{1, 3};
  logic [1:0] mMode[2];
  int         mK[2];
  int         mCnt[2];
  bit         mStep[2];
  bit         mDone[2];

  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] mode;
    logic [7:0] led;
    bit         step;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  led_chaser_multi #(.WIDTH(8), .DIV(1), .CNT_W(24)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .led(led1), .step(step1), .seq_done(done1)
  );

  led_chaser_multi #(.WIDTH(8), .DIV(3), .CNT_W(24)) dut3 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .led(led3), .step(step3), .seq_done(done3)
  );

  always #5 clk = ~clk;

  function automatic int period(input logic [1:0] m);
    case (m)
      2'd2:    return 14;
      2'd3:    return 9;
      default: return 8;
    endcase
  endfunction

  // Pattern shown at phase k of each mode's animation, from the mode's start pattern.
  function automatic logic [7:0] refPattern(input logic [1:0] m, input int k);
    logic [7:0] msb;
    logic [7:0] lsb;
    logic [7:0] ones;
    int pos;
    msb  = 8'h80;
    lsb  = 8'h01;
    ones = 8'hFF;
    case (m)
      2'd0: return msb >> k;
      2'd1: return lsb << k;
      2'd2: begin
        pos = (k <= 7) ? 7 - k : k - 7;
        return lsb << pos;
      end
      default: return (k == 0) ? 8'h00 : ~(ones >> k);
    endcase
  endfunction

  function automatic void modelUpdate(input bit r, input bit e, input logic [1:0] m);
    for (int i = 0; i < 2; i++) begin
      mStep[i] = 1'b0;
      mDone[i] = 1'b0;
      if (r || (m != mMode[i])) begin
        mMode[i] = m;
        mK[i]    = 0;
        mCnt[i]  = 0;
      end else if (e) begin
        if (mCnt[i] == mDiv[i] - 1) begin
          mCnt[i]  = 0;
          mK[i]    = (mK[i] + 1) % period(mMode[i]);
          mStep[i] = 1'b1;
          mDone[i] = (mK[i] == 0);
        end else begin
          mCnt[i] = mCnt[i] + 1;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] m);
    reset = r;
    en    = e;
    mode  = m;
    @(posedge clk);
    modelUpdate(r, e, m);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " led1"},  {24'd0, led1}, {24'd0, refPattern(mMode[0], mK[0])});
    checkOutput({tag, " step1"}, {31'd0, step1}, {31'd0, mStep[0]});
    checkOutput({tag, " done1"}, {31'd0, done1}, {31'd0, mDone[0]});
    checkOutput({tag, " led3"},  {24'd0, led3}, {24'd0, refPattern(mMode[1], mK[1])});
    checkOutput({tag, " step3"}, {31'd0, step3}, {31'd0, mStep[1]});
    checkOutput({tag, " done3"}, {31'd0, done3}, {31'd0, mDone[1]});
  endtask

  task automatic addVec(input bit r, input bit e, input logic [1:0] m,
                        input logic [7:0] l, input bit s, input bit d);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.mode = m;
    v.led  = l;
    v.step = s;
    v.done = d;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] shiftSeq[8];
    logic [7:0] fillSeq[9];
    int         n;
    bit         r, e;
    logic [1:0] m;

    shiftSeq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    fillSeq  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    reset = 1'b1;
    en    = 1'b0;
    mode  = 2'd0;

    // Shift-right full period, then a mode switch to fill-bar with a tick pending.
    addVec(1, 0, 2'd0, 8'h80, 0, 0);
    addVec(1, 0, 2'd0, 8'h80, 0, 0);
    for (int i = 0; i < 8; i++) addVec(0, 1, 2'd0, shiftSeq[i], 1, i == 7);
    for (int i = 0; i < 3; i++) addVec(0, 1, 2'd0, shiftSeq[i], 1, 0);
    addVec(0, 1, 2'd3, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) addVec(0, 1, 2'd3, fillSeq[i], 1, i == 8);
    addVec(0, 0, 2'd3, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].mode);
      checkOutput($sformatf("vec%0d led", i),  {24'd0, led1},  {24'd0, tbl[i].led});
      checkOutput($sformatf("vec%0d step", i), {31'd0, step1}, {31'd0, tbl[i].step});
      checkOutput($sformatf("vec%0d done", i), {31'd0, done1}, {31'd0, tbl[i].done});
    end

    // DIV=3 shift-left with an enable gap: prescaler count must survive the gap.
    applyStimulus(1, 0, 2'd1);
    checkOutput("div3 reset led", {24'd0, led3}, 32'h01);
    n = 0;
    for (int c = 0; c < 17; c++) begin
      e = !(c >= 7 && c < 12);
      applyStimulus(0, e, 2'd1);
      if (e) n++;
      checkOutput($sformatf("div3 led c%0d", c), {24'd0, led3}, 32'(8'h01 << (n / 3)));
      checkOutput($sformatf("div3 step c%0d", c), {31'd0, step3}, {31'd0, e && (n % 3 == 0)});
    end

    // Mode change mid-count: fill-bar starts at zero and first step comes DIV cycles later.
    applyStimulus(0, 1, 2'd3);
    checkOutput("div3 modechg led", {24'd0, led3}, 32'h00);
    checkOutput("div3 modechg step", {31'd0, step3}, 32'd0);
    applyStimulus(0, 1, 2'd3);
    applyStimulus(0, 1, 2'd3);
    checkOutput("div3 fill wait led", {24'd0, led3}, 32'h00);
    checkOutput("div3 fill wait step", {31'd0, step3}, 32'd0);
    applyStimulus(0, 1, 2'd3);
    checkOutput("div3 fill first led", {24'd0, led3}, 32'h80);
    checkOutput("div3 fill first step", {31'd0, step3}, 32'd1);

    // Bounce: full 14-step period, then on to 08 moving left, then reset.
    applyStimulus(1, 0, 2'd2);
    checkOutput("bounce reset led", {24'd0, led1}, 32'h80);
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(0, 1, 2'd2);
      checkOutput($sformatf("bounce led s%0d", i), {24'd0, led1}, {24'd0, refPattern(2'd2, i % 14)});
      checkOutput($sformatf("bounce done s%0d", i), {31'd0, done1}, {31'd0, i == 14});
    end
    checkOutput("bounce at 08", {24'd0, led1}, 32'h08);
    applyStimulus(1, 1, 2'd2);
    checkOutput("bounce rst led", {24'd0, led1}, 32'h80);
    checkOutput("bounce rst step", {31'd0, step1}, 32'd0);
    checkOutput("bounce rst done", {31'd0, done1}, 32'd0);
    applyStimulus(0, 1, 2'd2);
    checkOutput("bounce after rst led", {24'd0, led1}, 32'h40);
    checkOutput("bounce after rst step", {31'd0, step1}, 32'd1);

    // Random stimulus on both instances against the reference model.
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : mode;
      applyStimulus(r, e, m);
      checkAgainstModel($sformatf("rand c%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_chaser_multi.md
Name: led_chaser_multi

Overview:
Parametrised LED pattern generator driving an N-bit LED bank. It supports four selectable animation modes: shift-right, shift-left, bounce and fill-bar. Pattern advance is gated by an enable and an internal prescaler, so slow visible rates can be produced directly from the board clock. It sits between the board clock/switch inputs and the LED pins, and also exposes step and sequence-complete pulses for other display logic.

Parameters:
WIDTH, 8, number of LEDs; legal range 2..32.
DIV, 1, clock cycles per pattern step while enabled; legal range 1..2^24; DIV=1 means a step every enabled cycle.
CNT_W, 24, prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  when high, the prescaler runs and steps occur; when low, all state holds.
mode  input  2  0=shift-right, 1=shift-left, 2=bounce, 3=fill-bar.
led  output  WIDTH  registered LED pattern.
step  output  1  registered one-cycle pulse, high in the same cycle led shows a newly stepped value.
seq_done  output  1  registered one-cycle pulse, high together with step when led returns to the mode's start pattern.

Behaviour:
- Start pattern per mode:
  - mode 0: MSB one-hot (1000_0000 for WIDTH=8).
  - mode 1: LSB one-hot (0000_0001).
  - mode 2: MSB one-hot, direction = right.
  - mode 3: all zeros.
- Reset: led = start pattern of the mode input sampled in the reset cycle; mode_q = mode; cnt = 0; dir = right; step = 0; seq_done = 0.
- Prescaler: when en=1, cnt increments each cycle. When cnt == DIV-1, tick is asserted and cnt returns to 0 in the same cycle. When en=0, cnt holds. Tick is internal and combinational from cnt and en.
- Mode change: if mode != mode_q in a non-reset cycle, the block does all of the following:
  - loads the new mode's start pattern and sets dir = right;
  - clears cnt to 0 and sets mode_q = mode;
  - drives step = 0 and seq_done = 0.
  - This takes priority over a tick in the same cycle, and it happens regardless of en.
- Step (tick=1, no mode change): led takes the next pattern below, step = 1 on the next cycle, and seq_done = 1 on the next cycle if the next pattern equals the start pattern. Otherwise step = 0 and seq_done = 0.
  - mode 0: rotate right; bit0 wraps to MSB with no blank cycle. Period WIDTH.
  - mode 1: rotate left; MSB wraps to bit0. Period WIDTH.
  - mode 2: shift in dir. If dir = right and led = bit1, the step produces bit0 and dir becomes left. If dir = left and led = bit(WIDTH-2), the step produces MSB and dir becomes right. No bit is ever lit twice in succession. Period 2*WIDTH-2.
  - mode 3: if led = all ones, next = 0. Otherwise next = (led >> 1) | MSB, i.e. fill from the MSB downward. Period WIDTH+1.
- Illegal state recovery: if led holds a non-legal value for the current mode, the next step loads the start pattern. Non-legal means zero or multi-hot in modes 0–2, or a non-thermometer value in mode 3.
- Priority: reset > mode change > tick > hold.
- Reset asserted mid-sequence: led returns to the start pattern on the next edge; no step or seq_done pulse is produced.

Test Plan:
- WIDTH=8, DIV=1, mode=0, reset for 2 cycles then en=1 → led = 80,40,20,10,08,04,02,01,80 (hex). step is high every cycle. seq_done is high only on the cycle led shows 80.
- WIDTH=8, DIV=3, mode=1, en=1 → led changes every 3rd cycle: 01,02,04…80,01. Drop en for 5 cycles mid-sequence → led and cnt hold, and the step spacing stays 3 cycles after resume.
- WIDTH=8, DIV=1, mode=2 → led = 80,40,20,10,08,04,02,01,02,04…40,80. Period is 14 steps; seq_done fires on the 80 step; 01 is never repeated.
- WIDTH=8, DIV=1, mode=3 → led = 00,80,C0,E0,F0,F8,FC,FE,FF,00. seq_done fires when led returns to 00.
- Mode change: switch mode 0→3 while led = 10 with a tick pending → next led = 00, step = 0, cnt = 0. The first fill step (80) arrives DIV cycles later.
- Reset during bounce with dir = left and led = 08 → next led = 80, dir = right, step = 0, seq_done = 0, cnt = 0.
